mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single core-side memory port between the instruction-fetch memory interface and the load/store unit. It arbitrates requests round-robin and keeps each granted request stable until the memory accepts it. It limits in-flight requests to the memory's outstanding capacity and routes each answer back to its requester by access type. On a front-end flush it silently drops instruction answers that are still in flight, so the fetch side never sees stale instructions.

## Interface
- MAX_OUTSTANDING, 2, maximum requests accepted by memory but not yet answered (≥1); memory answers in order.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  front-end flush; affects instruction traffic only
- instr_valid_i / instr_ready_o  in/out  1  instruction request handshake
- instr_req_i  in  mem_req_t  instruction request
- instr_valid_o / instr_ready_i  out/in  1  instruction answer handshake
- instr_ans_o  out  mem_ans_t  instruction answer
- data_valid_i / data_ready_o  in/out  1  data request handshake
- data_req_i  in  mem_req_t  data request
- data_valid_o / data_ready_i  out/in  1  data answer handshake
- data_ans_o  out  mem_ans_t  data answer
- mem_valid_o / mem_ready_i  out/in  1  memory request handshake
- mem_req_o  out  mem_req_t  request to memory
- mem_valid_i / mem_ready_o  in/out  1  memory answer handshake
- mem_ans_i  in  mem_ans_t  answer from memory

## Operation
- State:
  - last_grant (INSTR/DATA).
  - lock (1 b) plus locked_grant.
  - out_cnt: total outstanding requests, width $clog2(MAX_OUTSTANDING+1).
  - instr_cnt: outstanding instruction requests.
  - discard_cnt: instruction answers still to be dropped.
- Request arbitration:
  - can_issue = out_cnt < MAX_OUTSTANDING, or an answer handshake occurs this cycle.
  - If lock is set, the grant is locked_grant.
  - Otherwise, with one requester valid, that requester wins. With both valid, the requester ≠ last_grant wins.
- Request forwarding:
  - mem_valid_o = can_issue & granted valid.
  - mem_req_o = granted request. With no requester valid, the grant defaults to INSTR.
  - The granted requester's ready = can_issue & mem_ready_i. The other requester's ready = 0.
- Lock: set when mem_valid_o & !mem_ready_i. Cleared on a request handshake. Cleared by flush_i when locked_grant = INSTR.
- last_grant updates on every request handshake.
- Counters:
  - out_cnt +1 on a request handshake, −1 on an answer handshake. Simultaneous events leave it unchanged.
  - instr_cnt tracks the same events for instruction requests and answers only.
- Answer routing: on mem_ans_i.acc_type == MEM_ACC_INSTR, route to instr, otherwise to data.
  - Routed to data: mem_ready_o = data_ready_i.
  - Routed to instr with discard_cnt > 0: drop the answer. mem_ready_o = 1, instr_valid_o = 0, discard_cnt −1.
  - Routed to instr otherwise: mem_ready_o = instr_ready_i, instr_valid_o = mem_valid_i.
- Flush:
  - discard_cnt <= instr_cnt + discard_cnt, minus any instruction answer accepted in the same cycle.
  - Instruction requests handshaken in the flush cycle are not counted into discard_cnt; the fetch side's own flush covers them.
  - Data traffic is unaffected.
- ans_o buses are wires from mem_ans_i; only the valids are gated.

## Timing
- Fully combinational datapath, 0-cycle latency on both directions. All state updates happen at posedge clk_i.
- Reset (asynchronous): last_grant = DATA, so INSTR wins the first tie. lock = 0, all counters = 0.
- With inputs idle at reset, all valid outputs are 0. mem_ready_o equals the addressed consumer's ready.
- Invariants (must be asserted in the bench):
  - out_cnt ≤ MAX_OUTSTANDING.
  - instr_cnt ≤ out_cnt.
  - mem_req_o stable while mem_valid_o & !mem_ready_i, unless a flush drops an INSTR lock.
- Counter underflow (an answer arriving with out_cnt = 0) is a protocol error: assertion only, no recovery.

## Structure
- memory_pkg gains mem_arb_grant_t (enum ARB_INSTR, ARB_DATA). mem_req_t, mem_ans_t and MEM_ACC_INSTR already live there.
- One sub-module: mem_arb_rr, the 2-way round-robin grant with lock (last_grant, lock, locked_grant).
- The counters and answer routing stay in the top module.

## Test plan
- Both requesters valid for 6 cycles, mem_ready_i = 1, answers returned promptly -> grants alternate I,D,I,D,I,D; first grant is INSTR.
- MAX_OUTSTANDING = 2, memory never answers, 3 back-to-back data requests -> 2 accepted, data_ready_o = 0 on the third. After one answer, the third is accepted in the same cycle as that answer.
- Data request held with mem_ready_i = 0 for 3 cycles while instr_valid_i rises -> mem_req_o stays the data request until accepted, then INSTR is granted.
- 2 instruction requests outstanding, flush_i pulsed, then 2 instruction answers followed by a 3rd -> first two answers dropped with mem_ready_o = 1 and instr_valid_o = 0; the third is forwarded.
- Flush in the same cycle as an instruction answer handshake, with 2 instruction requests outstanding -> discard_cnt = 1, exactly one later answer dropped.
- Asynchronous rst_i asserted mid-burst with a lock held -> all counters and lock cleared immediately; the next tie grants INSTR.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: shared memory request/answer types and the arbiter grant encoding.
package memory_pkg;
  typedef enum logic [1:0] {MEM_ACC_INSTR, MEM_ACC_LOAD, MEM_ACC_STORE} mem_acc_t;
  typedef struct packed {
    mem_acc_t    acc_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;
  typedef struct packed {
    mem_acc_t    acc_type;
    logic [31:0] rdata;
    logic        err;
  } mem_ans_t;
  typedef enum logic {ARB_INSTR, ARB_DATA} mem_arb_grant_t;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin grant that holds a stalled grant until the memory accepts it.
module mem_arb_rr
  import memory_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  input  logic           data_valid,
  input  logic           can_issue,
  input  logic           mem_ready,
  input  logic           flush,
  output mem_arb_grant_t grant,
  output logic           req_valid
);
  mem_arb_grant_t last_grant, locked_grant, free_grant;
  logic lock, hs;
  assign free_grant = (instr_valid & data_valid) ? (last_grant == ARB_DATA ? ARB_INSTR : ARB_DATA)
                                                 : (data_valid ? ARB_DATA : ARB_INSTR);
  assign grant = lock ? locked_grant : free_grant;
  assign req_valid = can_issue & (grant == ARB_INSTR ? instr_valid : data_valid);
  assign hs = req_valid & mem_ready;
  // A flush abandons a stalled fetch request, so it may release an instruction lock.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant   <= ARB_DATA;
      locked_grant <= ARB_INSTR;
      lock         <= 1'b0;
    end else begin
      if (hs) last_grant <= grant;
      if (hs || (flush && grant == ARB_INSTR)) lock <= 1'b0;
      else if (req_valid) begin
        lock         <= 1'b1;
        locked_grant <= grant;
      end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, bounding outstanding
// requests and routing in-order answers back, dropping fetch answers made stale by a flush.
module mem_port_arbiter
  import memory_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     instr_valid_i,
  output logic     instr_ready_o,
  input  mem_req_t instr_req_i,
  output logic     instr_valid_o,
  input  logic     instr_ready_i,
  output mem_ans_t instr_ans_o,
  input  logic     data_valid_i,
  output logic     data_ready_o,
  input  mem_req_t data_req_i,
  output logic     data_valid_o,
  input  logic     data_ready_i,
  output mem_ans_t data_ans_o,
  output logic     mem_valid_o,
  input  logic     mem_ready_i,
  output mem_req_t mem_req_o,
  input  logic     mem_valid_i,
  output logic     mem_ready_o,
  input  mem_ans_t mem_ans_i
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  // instr_cnt holds only live fetch requests; those marked stale by a flush move to discard_cnt.
  logic [CW-1:0] out_cnt, instr_cnt, discard_cnt;
  mem_arb_grant_t grant;
  logic can_issue, ans_instr, drop, ans_hs, drop_hs, fwd_hs, req_hs, req_instr;
  assign ans_instr     = mem_ans_i.acc_type == MEM_ACC_INSTR;
  assign drop          = ans_instr & (discard_cnt != '0);
  assign mem_ready_o   = ans_instr ? (drop | instr_ready_i) : data_ready_i;
  assign instr_valid_o = mem_valid_i & ans_instr & !drop;
  assign data_valid_o  = mem_valid_i & !ans_instr;
  assign instr_ans_o   = mem_ans_i;
  assign data_ans_o    = mem_ans_i;
  assign ans_hs        = mem_valid_i & mem_ready_o;
  assign drop_hs       = ans_hs & drop;
  assign fwd_hs        = ans_hs & ans_instr & !drop;
  assign can_issue     = (out_cnt < CW'(MAX_OUTSTANDING)) | ans_hs;
  mem_arb_rr u_rr (
    .clk        (clk_i),
    .rst        (rst_i),
    .instr_valid(instr_valid_i),
    .data_valid (data_valid_i),
    .can_issue  (can_issue),
    .mem_ready  (mem_ready_i),
    .flush      (flush_i),
    .grant      (grant),
    .req_valid  (mem_valid_o)
  );
  assign mem_req_o     = grant == ARB_INSTR ? instr_req_i : data_req_i;
  assign instr_ready_o = can_issue & mem_ready_i & (grant == ARB_INSTR);
  assign data_ready_o  = can_issue & mem_ready_i & (grant == ARB_DATA);
  assign req_hs        = mem_valid_o & mem_ready_i;
  assign req_instr     = req_hs & (grant == ARB_INSTR);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      out_cnt     <= '0;
      instr_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      out_cnt     <= out_cnt + CW'(req_hs) - CW'(ans_hs);
      instr_cnt   <= flush_i ? CW'(req_instr) : instr_cnt + CW'(req_instr) - CW'(fwd_hs);
      discard_cnt <= flush_i ? discard_cnt + instr_cnt - CW'(drop_hs) - CW'(fwd_hs)
                             : discard_cnt - CW'(drop_hs);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations plus per-cycle invariants.
module tb_mem_port_arbiter;
  import memory_pkg::*;
  localparam int MAX = 2;
  logic clk_i = 1'b0, rst_i, flush_i;
  logic instr_valid_i, instr_ready_o, instr_valid_o, instr_ready_i;
  logic data_valid_i, data_ready_o, data_valid_o, data_ready_i;
  logic mem_valid_o, mem_ready_i, mem_valid_i, mem_ready_o;
  mem_req_t instr_req_i, data_req_i, mem_req_o;
  mem_ans_t instr_ans_o, data_ans_o, mem_ans_i;
  int n_cmp = 0, n_bad = 0;
  logic hold = 1'b0;
  logic [31:0] hold_addr;
  mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_req_i(instr_req_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_ans_o(instr_ans_o),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_req_i(data_req_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_ans_o(data_ans_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_ans_i(mem_ans_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic mem_req_t rq(input mem_acc_t a, input logic [31:0] addr);
    return '{acc_type: a, addr: addr, wdata: addr ^ 32'hA5A5_0000, be: 4'hF};
  endfunction
  function automatic mem_ans_t an(input mem_acc_t a, input logic [31:0] d);
    return '{acc_type: a, rdata: d, err: 1'b0};
  endfunction
  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask
  task automatic smp;
    @(negedge clk_i);
  endtask
  task automatic idle;
    instr_valid_i = 0; data_valid_i = 0; mem_valid_i = 0; flush_i = 0;
    mem_ready_i = 1; instr_ready_i = 1; data_ready_i = 1;
    mem_ans_i = an(MEM_ACC_INSTR, 0);
  endtask
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("inv_out_le_max", 32'(dut.out_cnt <= MAX), 1);
      chk("inv_instr_le_out", 32'(dut.instr_cnt <= dut.out_cnt), 1);
      if (hold) chk("inv_req_stable", mem_req_o.addr, hold_addr);
      if (mem_valid_i && mem_ready_o) chk("inv_no_underflow", 32'(dut.out_cnt != 0), 1);
    end
    hold = !rst_i & mem_valid_o & !mem_ready_i & !(flush_i & dut.grant == ARB_INSTR);
    hold_addr = mem_req_o.addr;
  end
  initial begin
    rst_i = 1;
    idle();
    mem_ready_i = 0;
    instr_req_i = rq(MEM_ACC_INSTR, 32'h100);
    data_req_i = rq(MEM_ACC_LOAD, 32'h200);
    smp();
    chk("rst_mem_valid", 32'(mem_valid_o), 0);
    chk("rst_instr_valid", 32'(instr_valid_o), 0);
    chk("rst_data_valid", 32'(data_valid_o), 0);
    chk("rst_mem_ready", 32'(mem_ready_o), 1);
    chk("rst_out_cnt", 32'(dut.out_cnt), 0);
    nxt();
    rst_i = 0;
    // round-robin alternation with prompt answers
    for (int i = 0; i < 6; i++) begin
      instr_valid_i = 1; data_valid_i = 1; mem_ready_i = 1;
      mem_valid_i = i > 0;
      mem_ans_i = an(i % 2 == 1 ? MEM_ACC_INSTR : MEM_ACC_LOAD, 32'(i));
      smp();
      chk("rr_addr", mem_req_o.addr, i % 2 == 0 ? 32'h100 : 32'h200);
      chk("rr_valid", 32'(mem_valid_o), 1);
      if (i > 0) chk("rr_ans_route", 32'({instr_valid_o, data_valid_o}), i % 2 == 1 ? 2 : 1);
      nxt();
    end
    idle();
    mem_valid_i = 1; mem_ans_i = an(MEM_ACC_LOAD, 32'h55);
    smp();
    chk("rr_last_ans", 32'(data_valid_o), 1);
    chk("rr_last_rdata", data_ans_o.rdata, 32'h55);
    nxt();
    idle();
    smp();
    chk("rr_out_cnt", 32'(dut.out_cnt), 0);
    // outstanding limit
    nxt();
    data_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("lim_ready", 32'(data_ready_o), i < 2 ? 1 : 0);
      chk("lim_mem_valid", 32'(mem_valid_o), i < 2 ? 1 : 0);
      nxt();
    end
    mem_valid_i = 1; mem_ans_i = an(MEM_ACC_LOAD, 32'h1);
    smp();
    chk("lim_ready_on_ans", 32'(data_ready_o), 1);
    chk("lim_data_valid", 32'(data_valid_o), 1);
    nxt();
    data_valid_i = 0;
    smp();
    chk("lim_out_full", 32'(dut.out_cnt), 2);
    nxt();
    nxt();
    mem_valid_i = 0;
    smp();
    chk("lim_drained", 32'(dut.out_cnt), 0);
    // lock holds a stalled data request while fetch rises
    nxt();
    idle();
    data_req_i = rq(MEM_ACC_LOAD, 32'h300);
    instr_req_i = rq(MEM_ACC_INSTR, 32'h104);
    data_valid_i = 1; mem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("lock_addr", mem_req_o.addr, 32'h300);
      chk("lock_instr_ready", 32'(instr_ready_o), 0);
      nxt();
      instr_valid_i = 1;
    end
    mem_ready_i = 1;
    smp();
    chk("lock_accept", 32'(data_ready_o), 1);
    chk("lock_accept_addr", mem_req_o.addr, 32'h300);
    nxt();
    data_valid_i = 0;
    smp();
    chk("lock_then_instr", mem_req_o.addr, 32'h104);
    chk("lock_instr_ready2", 32'(instr_ready_o), 1);
    nxt();
    instr_valid_i = 0; mem_valid_i = 1; mem_ans_i = an(MEM_ACC_LOAD, 0);
    nxt();
    mem_ans_i = an(MEM_ACC_INSTR, 0);
    nxt();
    idle();
    smp();
    chk("lock_out_cnt", 32'(dut.out_cnt), 0);
    // flush drops two in-flight fetch answers
    nxt();
    instr_valid_i = 1;
    nxt();
    nxt();
    instr_valid_i = 0; flush_i = 1;
    nxt();
    flush_i = 0; instr_valid_i = 1; instr_ready_i = 0;
    mem_valid_i = 1; mem_ans_i = an(MEM_ACC_INSTR, 32'hC1);
    smp();
    chk("fl_discard", 32'(dut.discard_cnt), 2);
    chk("fl_drop1_ready", 32'(mem_ready_o), 1);
    chk("fl_drop1_valid", 32'(instr_valid_o), 0);
    chk("fl_new_req", 32'(instr_ready_o), 1);
    nxt();
    instr_valid_i = 0; mem_ans_i = an(MEM_ACC_INSTR, 32'hC2);
    smp();
    chk("fl_drop2_ready", 32'(mem_ready_o), 1);
    chk("fl_drop2_valid", 32'(instr_valid_o), 0);
    nxt();
    instr_ready_i = 1; mem_ans_i = an(MEM_ACC_INSTR, 32'hC3);
    smp();
    chk("fl_fwd_valid", 32'(instr_valid_o), 1);
    chk("fl_fwd_rdata", instr_ans_o.rdata, 32'hC3);
    nxt();
    idle();
    smp();
    chk("fl_out_cnt", 32'(dut.out_cnt), 0);
    chk("fl_discard_end", 32'(dut.discard_cnt), 0);
    // flush coinciding with an accepted fetch answer
    nxt();
    instr_valid_i = 1;
    nxt();
    nxt();
    instr_valid_i = 0; flush_i = 1; mem_valid_i = 1; mem_ans_i = an(MEM_ACC_INSTR, 32'hD1);
    smp();
    chk("flc_fwd", 32'(instr_valid_o), 1);
    nxt();
    flush_i = 0; instr_ready_i = 0; mem_ans_i = an(MEM_ACC_INSTR, 32'hD2);
    smp();
    chk("flc_discard", 32'(dut.discard_cnt), 1);
    chk("flc_drop_ready", 32'(mem_ready_o), 1);
    chk("flc_drop_valid", 32'(instr_valid_o), 0);
    nxt();
    mem_valid_i = 0; instr_ready_i = 1; instr_valid_i = 1;
    nxt();
    instr_valid_i = 0; mem_valid_i = 1; mem_ans_i = an(MEM_ACC_INSTR, 32'hD3);
    smp();
    chk("flc_next_fwd", 32'(instr_valid_o), 1);
    chk("flc_next_discard", 32'(dut.discard_cnt), 0);
    nxt();
    idle();
    smp();
    chk("flc_out_cnt", 32'(dut.out_cnt), 0);
    // asynchronous reset with a lock held
    nxt();
    instr_valid_i = 1;
    nxt();
    instr_valid_i = 0; data_valid_i = 1; mem_ready_i = 0;
    data_req_i = rq(MEM_ACC_STORE, 32'h400);
    nxt();
    smp();
    chk("ar_lock_held", 32'(dut.u_rr.lock), 1);
    chk("ar_out_before", 32'(dut.out_cnt), 1);
    #2 rst_i = 1;
    #1;
    chk("ar_out_cnt", 32'(dut.out_cnt), 0);
    chk("ar_instr_cnt", 32'(dut.instr_cnt), 0);
    chk("ar_lock", 32'(dut.u_rr.lock), 0);
    smp();
    nxt();
    rst_i = 0; instr_valid_i = 1; data_valid_i = 1; mem_ready_i = 1;
    smp();
    chk("ar_tie_instr", mem_req_o.addr, 32'h104);
    nxt();
    idle();
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
